// File: rtl/cntr8_cmd_gen.sv
// Command stage for the 8-bit counter: synchronises and debounces the inc/load buttons,
// adds auto-repeat on a held inc button and arbitrates inc/load into single-cycle commands.
module cntr8_cmd_gen #(
    parameter int unsigned DB_CYCLES  = 4,
    parameter int unsigned RPT_DELAY  = 16,
    parameter int unsigned RPT_PERIOD = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       btn_inc,
    input  logic       btn_load,
    input  logic [7:0] sw_val,
    output logic       inc,
    output logic       load,
    output logic [7:0] d_in,
    output logic       rpt_active
);

    localparam int unsigned DATA_W   = 8;
    localparam int unsigned TIMER_W  = 16;
    localparam int unsigned BTN_N    = 2;
    localparam int unsigned BTN_INC  = 0;
    localparam int unsigned BTN_LOAD = 1;
    localparam int unsigned CNT_W    = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        RPT  = 2'd2
    } inc_state_t;

    logic [BTN_N-1:0]  btn_s1, btn_s2;
    logic [DATA_W-1:0] sw_s1, sw_s2;
    logic [BTN_N-1:0]  db, db_q;
    logic [CNT_W-1:0]  db_cnt [BTN_N];
    logic [BTN_N-1:0]  press;

    inc_state_t         state_q, state_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic               inc_req;
    logic               inc_pend;
    logic               inc_want;

    // Two-flop synchronisers for both buttons and the switch bus
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            btn_s1 <= '0;
            btn_s2 <= '0;
            sw_s1  <= '0;
            sw_s2  <= '0;
        end else begin
            btn_s1 <= {btn_load, btn_inc};
            btn_s2 <= btn_s1;
            sw_s1  <= sw_val;
            sw_s2  <= sw_s1;
        end
    end

    // Debounce: accept a new level only after DB_CYCLES consecutive differing samples
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            db   <= '0;
            db_q <= '0;
            for (int i = 0; i < BTN_N; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            db_q <= db;
            for (int i = 0; i < BTN_N; i++) begin
                if (btn_s2[i] == db[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == CNT_W'(DB_CYCLES - 1)) begin
                    db[i]     <= btn_s2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    assign press = db & ~db_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
        end
    end

    // Inc auto-repeat FSM; the timer restarts on every state change and every request
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        inc_req = 1'b0;
        case (state_q)
            IDLE: begin
                if (press[BTN_INC]) begin
                    inc_req = 1'b1;
                    state_d = HOLD;
                    timer_d = '0;
                end
            end
            HOLD: begin
                if (!db[BTN_INC]) begin
                    state_d = IDLE;
                    timer_d = '0;
                end else if (timer_q == TIMER_W'(RPT_DELAY - 1)) begin
                    inc_req = 1'b1;
                    state_d = RPT;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + TIMER_W'(1);
                end
            end
            RPT: begin
                if (!db[BTN_INC]) begin
                    state_d = IDLE;
                    timer_d = '0;
                end else if (timer_q == TIMER_W'(RPT_PERIOD - 1)) begin
                    inc_req = 1'b1;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + TIMER_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                timer_d = '0;
            end
        endcase
    end

    assign inc_want = inc_req | inc_pend;

    // Load has priority; a displaced inc waits one cycle in the pending flag
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            inc        <= 1'b0;
            load       <= 1'b0;
            d_in       <= '0;
            inc_pend   <= 1'b0;
            rpt_active <= 1'b0;
        end else begin
            rpt_active <= (state_d == RPT);
            if (press[BTN_LOAD]) begin
                load     <= 1'b1;
                d_in     <= sw_s2;
                inc      <= 1'b0;
                inc_pend <= inc_want;
            end else begin
                load     <= 1'b0;
                inc      <= inc_want;
                inc_pend <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_cntr8_cmd_gen.sv
// Bench for cntr8_cmd_gen: directed vector table, hand-written repeat/reset sequences,
// then randomized bouncy buttons checked against a history-based reference model.
module tb_cntr8_cmd_gen;

    localparam int DB_CYCLES  = 4;
    localparam int RPT_DELAY  = 16;
    localparam int RPT_PERIOD = 8;

    logic       clk      = 1'b0;
    logic       reset_n  = 1'b0;
    logic       btn_inc  = 1'b0;
    logic       btn_load = 1'b0;
    logic [7:0] sw_val   = 8'h00;
    logic       inc;
    logic       load;
    logic [7:0] d_in;
    logic       rpt_active;

    int checks = 0;
    int errors = 0;

    cntr8_cmd_gen #(
        .DB_CYCLES (DB_CYCLES),
        .RPT_DELAY (RPT_DELAY),
        .RPT_PERIOD(RPT_PERIOD)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .btn_inc   (btn_inc),
        .btn_load  (btn_load),
        .sw_val    (sw_val),
        .inc       (inc),
        .load      (load),
        .d_in      (d_in),
        .rpt_active(rpt_active)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Debounce: level follows the synchronised input once the last DB_CYCLES samples all
    // disagree with it. Inc requests: at the press, then at hold ages RPT_DELAY and every
    // RPT_PERIOD after that.
    logic [1:0]           m_s1, m_s2, m_db, m_dbq;
    logic [7:0]           m_sw1, m_sw2;
    bit [DB_CYCLES-1:0]   m_hist [2];
    bit                   m_held, m_pend;
    int                   m_age;
    logic                 m_inc, m_load, m_rpt;
    logic [7:0]           m_d;
    bit                   p_inc, p_load, req, want;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_s1 = '0; m_s2 = '0; m_db = '0; m_dbq = '0;
            m_sw1 = '0; m_sw2 = '0;
            m_hist[0] = '0; m_hist[1] = '0;
            m_held = 0; m_pend = 0; m_age = 0;
            m_inc = 0; m_load = 0; m_rpt = 0; m_d = '0;
        end else begin
            p_inc  = m_db[0] & ~m_dbq[0];
            p_load = m_db[1] & ~m_dbq[1];
            req = 0;
            if (p_inc) begin
                m_held = 1;
                m_age  = 0;
                req    = 1;
            end else if (m_held && m_db[0]) begin
                m_age++;
                req = (m_age == RPT_DELAY) ||
                      (m_age > RPT_DELAY && ((m_age - RPT_DELAY) % RPT_PERIOD) == 0);
            end else begin
                m_held = 0;
            end
            m_rpt = m_held && (m_age >= RPT_DELAY);
            want  = req | m_pend;
            if (p_load) begin
                m_load = 1;
                m_d    = m_sw2;
                m_inc  = 0;
                m_pend = want;
            end else begin
                m_load = 0;
                m_inc  = want;
                m_pend = 0;
            end
            m_dbq = m_db;
            for (int b = 0; b < 2; b++) begin
                m_hist[b] = (m_hist[b] << 1) | DB_CYCLES'(m_s2[b]);
                if (m_hist[b] == {DB_CYCLES{~m_db[b]}}) m_db[b] = m_s2[b];
            end
            m_s2  = m_s1;
            m_s1  = {btn_load, btn_inc};
            m_sw2 = m_sw1;
            m_sw1 = sw_val;
        end
    end

    // ---------------- directed vector table ----------------
    typedef struct {
        logic       bi;
        logic       bl;
        logic [7:0] sw;
        logic       e_inc;
        logic       e_load;
        logic [7:0] e_d;
        logic       e_rpt;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic bi, input logic bl, input logic [7:0] sw,
                       input logic ei, input logic el, input logic [7:0] ed, input logic er);
        vec_t v;
        v.bi = bi; v.bl = bl; v.sw = sw;
        v.e_inc = ei; v.e_load = el; v.e_d = ed; v.e_rpt = er;
        tbl.push_back(v);
    endtask

    logic lvl_inc, lvl_load;

    initial begin
        // clean inc press held 12 cycles: one pulse on the 7th edge
        for (int r = 0; r < 12; r++) add(1'b1, 1'b0, 8'h00, r == 6, 1'b0, 8'h00, 1'b0);
        for (int r = 0; r < 10; r++) add(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
        // bouncy load: 3 high, 2 low, then steady high
        for (int r = 0; r < 15; r++)
            add(1'b0, !(r == 3 || r == 4), 8'hA5, 1'b0, r == 11, (r >= 11) ? 8'hA5 : 8'h00, 1'b0);
        for (int r = 0; r < 10; r++) add(1'b0, 1'b0, 8'hA5, 1'b0, 1'b0, 8'hA5, 1'b0);
        // collision: load first, displaced inc one cycle later
        for (int r = 0; r < 10; r++)
            add(1'b1, 1'b1, 8'h3C, r == 7, r == 6, (r >= 6) ? 8'h3C : 8'hA5, 1'b0);
        for (int r = 0; r < 12; r++) add(1'b0, 1'b0, 8'h3C, 1'b0, 1'b0, 8'h3C, 1'b0);

        // reset held while inputs toggle
        for (int r = 0; r < 8; r++) begin
            btn_inc  = r[0];
            btn_load = r[1];
            sw_val   = 8'($urandom);
            @(negedge clk);
            check("rst_inc", 8'(inc), 8'h00);
            check("rst_load", 8'(load), 8'h00);
            check("rst_d", d_in, 8'h00);
            check("rst_rpt", 8'(rpt_active), 8'h00);
        end
        btn_inc = 0; btn_load = 0; sw_val = 8'h00;
        reset_n = 1'b1;
        for (int r = 0; r < 5; r++) @(negedge clk);

        foreach (tbl[i]) begin
            btn_inc  = tbl[i].bi;
            btn_load = tbl[i].bl;
            sw_val   = tbl[i].sw;
            @(negedge clk);
            check("tbl_inc", 8'(inc), 8'(tbl[i].e_inc));
            check("tbl_load", 8'(load), 8'(tbl[i].e_load));
            check("tbl_d", d_in, tbl[i].e_d);
            check("tbl_rpt", 8'(rpt_active), 8'(tbl[i].e_rpt));
        end

        // auto-repeat: held 60 cycles, pulses at rows 6, 22, 30 ... 62
        for (int r = 0; r < 80; r++) begin
            btn_inc = (r < 60);
            @(negedge clk);
            check("rpt_inc", 8'(inc), 8'((r == 6) || (r >= 22 && r <= 62 && ((r - 22) % 8) == 0)));
            check("rpt_load", 8'(load), 8'h00);
            check("rpt_flag", 8'(rpt_active), 8'(r >= 22 && r <= 65));
        end

        // async reset in the middle of repeat, right on an inc pulse
        for (int r = 0; r < 39; r++) begin
            btn_inc = 1'b1;
            @(negedge clk);
        end
        check("pre_rst_inc", 8'(inc), 8'h01);
        check("pre_rst_rpt", 8'(rpt_active), 8'h01);
        #2 reset_n = 1'b0;
        #1;
        check("arst_inc", 8'(inc), 8'h00);
        check("arst_load", 8'(load), 8'h00);
        check("arst_d", d_in, 8'h00);
        check("arst_rpt", 8'(rpt_active), 8'h00);
        btn_inc = 1'b0;
        for (int r = 0; r < 3; r++) @(negedge clk);
        reset_n = 1'b1;
        for (int r = 0; r < 30; r++) begin
            @(negedge clk);
            check("post_rst_inc", 8'(inc), 8'h00);
            check("post_rst_rpt", 8'(rpt_active), 8'h00);
        end
        for (int r = 0; r < 10; r++) begin
            btn_inc = 1'b1;
            @(negedge clk);
            check("repress_inc", 8'(inc), 8'(r == 6));
        end
        btn_inc = 1'b0;
        for (int r = 0; r < 12; r++) @(negedge clk);

        // randomized bouncy buttons against the model
        lvl_inc  = 1'b0;
        lvl_load = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 59) == 0) lvl_inc = ~lvl_inc;
            if ($urandom_range(0, 29) == 0) lvl_load = ~lvl_load;
            btn_inc  = ($urandom_range(0, 9) == 0) ? ~lvl_inc : lvl_inc;
            btn_load = ($urandom_range(0, 9) == 0) ? ~lvl_load : lvl_load;
            if ($urandom_range(0, 15) == 0) sw_val = 8'($urandom);
            if (i == 1503) reset_n = 1'b1;
            @(negedge clk);
            check("rnd_inc", 8'(inc), 8'(m_inc));
            check("rnd_load", 8'(load), 8'(m_load));
            check("rnd_d", d_in, m_d);
            check("rnd_rpt", 8'(rpt_active), 8'(m_rpt));
            check("rnd_excl", 8'(inc & load), 8'h00);
            if (i == 1500) #2 reset_n = 1'b0;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
